// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the memory (slave).
interface memory_access_stage_if;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_RDATA, MEM_ACK
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_RDATA, MEM_ACK
    );
endinterface

// File: rtl/memory_access_stage.sv
// MEM stage of the 32-bit RISC pipeline: data-memory loads/stores with timeout,
// branch resolution and registered write-back fields.
module memory_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        VALID_IN,
    input  logic [31:0]                 ALU_RESULT,
    input  logic [31:0]                 WRITE_DATA,
    input  logic [4:0]                  WRITE_REGISTER,
    input  logic [31:0]                 BRANCH_TARGET,
    input  logic                        ZERO,
    input  logic [4:0]                  CONTROL,
    input  logic                        HIT,
    output logic                        STALL,
    memory_access_stage_if.master       mem,
    output logic                        PC_SRC,
    output logic [31:0]                 BRANCH_TARGET_OUT,
    output logic                        WB_VALID,
    output logic                        WB_REG_WRITE,
    output logic                        WB_MEM_TO_REG,
    output logic [31:0]                 WB_ALU_RESULT,
    output logic [31:0]                 WB_READ_DATA,
    output logic [4:0]                  WB_WRITE_REGISTER,
    output logic                        HIT_OUT,
    output logic                        BUS_ERROR
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    // A zero TIMEOUT still needs a one-bit counter; it simply saturates.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              is_mem_s;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              pc_src_q, pc_src_d;
    logic [31:0]       bt_out_q, bt_out_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [31:0]       wb_alu_result_q, wb_alu_result_d;
    logic [31:0]       wb_read_data_q, wb_read_data_d;
    logic [4:0]        wb_write_register_q, wb_write_register_d;
    logic              hit_out_q, hit_out_d;
    logic              bus_error_q, bus_error_d;

    // Next-state and next-output computation for the IDLE/BUSY controller.
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        mem_req_d           = mem_req_q;
        mem_we_d            = mem_we_q;
        mem_addr_d          = mem_addr_q;
        mem_wdata_d         = mem_wdata_q;
        pc_src_d            = 1'b0;
        bt_out_d            = bt_out_q;
        wb_valid_d          = 1'b0;
        wb_reg_write_d      = wb_reg_write_q;
        wb_mem_to_reg_d     = wb_mem_to_reg_q;
        wb_alu_result_d     = wb_alu_result_q;
        wb_read_data_d      = wb_read_data_q;
        wb_write_register_d = wb_write_register_q;
        hit_out_d           = hit_out_q;
        bus_error_d         = bus_error_q;
        is_mem_s            = CONTROL[3] | CONTROL[2];
        cnt_inc_s           = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (VALID_IN) begin
                    wb_alu_result_d     = ALU_RESULT;
                    wb_write_register_d = WRITE_REGISTER;
                    wb_reg_write_d      = CONTROL[1];
                    wb_mem_to_reg_d     = CONTROL[0];
                    hit_out_d           = HIT;
                    if (!is_mem_s) begin
                        wb_valid_d = 1'b1;
                        pc_src_d   = CONTROL[4] & ZERO;
                        bt_out_d   = BRANCH_TARGET;
                    end else if (ALU_RESULT[1:0] == 2'b00) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = CONTROL[2];
                        mem_addr_d  = ALU_RESULT;
                        mem_wdata_d = WRITE_DATA;
                        cnt_d       = '0;
                        state_d     = ST_BUSY;
                    end else begin
                        bus_error_d    = 1'b1;
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc_s;
                if (mem.MEM_ACK) begin
                    if (!mem_we_q) begin
                        wb_read_data_d = mem.MEM_RDATA;
                    end else begin
                        wb_read_data_d = wb_read_data_q;
                    end
                    wb_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = ST_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_inc_s == CNT_LIMIT)) begin
                    bus_error_d    = 1'b1;
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    mem_req_d      = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q             <= ST_IDLE;
            cnt_q               <= '0;
            mem_req_q           <= 1'b0;
            mem_we_q            <= 1'b0;
            mem_addr_q          <= 32'h0000_0000;
            mem_wdata_q         <= 32'h0000_0000;
            pc_src_q            <= 1'b0;
            bt_out_q            <= 32'h0000_0000;
            wb_valid_q          <= 1'b0;
            wb_reg_write_q      <= 1'b0;
            wb_mem_to_reg_q     <= 1'b0;
            wb_alu_result_q     <= 32'h0000_0000;
            wb_read_data_q      <= 32'h0000_0000;
            wb_write_register_q <= 5'd0;
            hit_out_q           <= 1'b0;
            bus_error_q         <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            mem_req_q           <= mem_req_d;
            mem_we_q            <= mem_we_d;
            mem_addr_q          <= mem_addr_d;
            mem_wdata_q         <= mem_wdata_d;
            pc_src_q            <= pc_src_d;
            bt_out_q            <= bt_out_d;
            wb_valid_q          <= wb_valid_d;
            wb_reg_write_q      <= wb_reg_write_d;
            wb_mem_to_reg_q     <= wb_mem_to_reg_d;
            wb_alu_result_q     <= wb_alu_result_d;
            wb_read_data_q      <= wb_read_data_d;
            wb_write_register_q <= wb_write_register_d;
            hit_out_q           <= hit_out_d;
            bus_error_q         <= bus_error_d;
        end
    end

    assign STALL             = (state_q == ST_BUSY);
    assign mem.MEM_REQ       = mem_req_q;
    assign mem.MEM_WE        = mem_we_q;
    assign mem.MEM_ADDR      = mem_addr_q;
    assign mem.MEM_WDATA     = mem_wdata_q;
    assign PC_SRC            = pc_src_q;
    assign BRANCH_TARGET_OUT = bt_out_q;
    assign WB_VALID          = wb_valid_q;
    assign WB_REG_WRITE      = wb_reg_write_q;
    assign WB_MEM_TO_REG     = wb_mem_to_reg_q;
    assign WB_ALU_RESULT     = wb_alu_result_q;
    assign WB_READ_DATA      = wb_read_data_q;
    assign WB_WRITE_REGISTER = wb_write_register_q;
    assign HIT_OUT           = hit_out_q;
    assign BUS_ERROR         = bus_error_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage (TIMEOUT = 16).
module tb_memory_access_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        VALID_IN;
    logic [31:0] ALU_RESULT;
    logic [31:0] WRITE_DATA;
    logic [4:0]  WRITE_REGISTER;
    logic [31:0] BRANCH_TARGET;
    logic        ZERO;
    logic [4:0]  CONTROL;
    logic        HIT;
    logic        STALL;
    logic        PC_SRC;
    logic [31:0] BRANCH_TARGET_OUT;
    logic        WB_VALID;
    logic        WB_REG_WRITE;
    logic        WB_MEM_TO_REG;
    logic [31:0] WB_ALU_RESULT;
    logic [31:0] WB_READ_DATA;
    logic [4:0]  WB_WRITE_REGISTER;
    logic        HIT_OUT;
    logic        BUS_ERROR;

    int total  = 0;
    int passed = 0;

    memory_access_stage_if bus ();

    memory_access_stage #(.TIMEOUT(16)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .VALID_IN          (VALID_IN),
        .ALU_RESULT        (ALU_RESULT),
        .WRITE_DATA        (WRITE_DATA),
        .WRITE_REGISTER    (WRITE_REGISTER),
        .BRANCH_TARGET     (BRANCH_TARGET),
        .ZERO              (ZERO),
        .CONTROL           (CONTROL),
        .HIT               (HIT),
        .STALL             (STALL),
        .mem               (bus),
        .PC_SRC            (PC_SRC),
        .BRANCH_TARGET_OUT (BRANCH_TARGET_OUT),
        .WB_VALID          (WB_VALID),
        .WB_REG_WRITE      (WB_REG_WRITE),
        .WB_MEM_TO_REG     (WB_MEM_TO_REG),
        .WB_ALU_RESULT     (WB_ALU_RESULT),
        .WB_READ_DATA      (WB_READ_DATA),
        .WB_WRITE_REGISTER (WB_WRITE_REGISTER),
        .HIT_OUT           (HIT_OUT),
        .BUS_ERROR         (BUS_ERROR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        VALID_IN = 1'b0; ALU_RESULT = 32'h0; WRITE_DATA = 32'h0; WRITE_REGISTER = 5'd0;
        BRANCH_TARGET = 32'h0; ZERO = 1'b0; CONTROL = 5'b00000; HIT = 1'b0;
        bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic issue(input logic [4:0] ctrl, input logic [31:0] alu,
                         input logic [31:0] wdata, input logic [4:0] wreg);
        VALID_IN = 1'b1; CONTROL = ctrl; ALU_RESULT = alu; WRITE_DATA = wdata; WRITE_REGISTER = wreg;
        tick();
        VALID_IN = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({STALL, bus.MEM_REQ, bus.MEM_WE, PC_SRC, WB_VALID, WB_REG_WRITE, WB_MEM_TO_REG, HIT_OUT, BUS_ERROR} !== 9'b0)
            $display("FAIL reset_flags: got %b expected 000000000",
                     {STALL, bus.MEM_REQ, bus.MEM_WE, PC_SRC, WB_VALID, WB_REG_WRITE, WB_MEM_TO_REG, HIT_OUT, BUS_ERROR});
        else passed++;
        total++;
        if ({bus.MEM_ADDR, bus.MEM_WDATA, BRANCH_TARGET_OUT, WB_ALU_RESULT, WB_READ_DATA, WB_WRITE_REGISTER} !== 165'b0)
            $display("FAIL reset_buses: got nonzero, addr=%h alu=%h rd=%h", bus.MEM_ADDR, WB_ALU_RESULT, WB_READ_DATA);
        else passed++;
    endtask

    task automatic test_alu();
        HIT = 1'b1;
        issue(5'b00010, 32'h5, 32'h0, 5'd3);
        HIT = 1'b0;
        total++;
        if ({WB_VALID, WB_REG_WRITE, STALL, HIT_OUT, WB_MEM_TO_REG} !== 5'b11010)
            $display("FAIL alu_flags: got %b expected 11010", {WB_VALID, WB_REG_WRITE, STALL, HIT_OUT, WB_MEM_TO_REG});
        else passed++;
        total++;
        if (WB_ALU_RESULT !== 32'h5 || WB_WRITE_REGISTER !== 5'd3)
            $display("FAIL alu_data: got %h/%0d expected 00000005/3", WB_ALU_RESULT, WB_WRITE_REGISTER);
        else passed++;
        tick();
        total++;
        if (WB_VALID !== 1'b0 || WB_ALU_RESULT !== 32'h5)
            $display("FAIL alu_hold: got valid=%b alu=%h expected 0/00000005", WB_VALID, WB_ALU_RESULT);
        else passed++;
    endtask

    task automatic test_load();
        int stall_cnt = 0;
        issue(5'b01011, 32'h100, 32'h0, 5'd7);
        total++;
        if (bus.MEM_REQ !== 1'b1 || bus.MEM_WE !== 1'b0 || bus.MEM_ADDR !== 32'h100)
            $display("FAIL load_req: got req=%b we=%b addr=%h expected 1/0/00000100", bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            if (STALL === 1'b1) stall_cnt++;
            if (i == 2) begin bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hCAFEF00D; end
            tick();
        end
        bus.MEM_ACK = 1'b0;
        total++;
        if (stall_cnt != 3 || STALL !== 1'b0 || bus.MEM_REQ !== 1'b0)
            $display("FAIL load_stall: got stall_cycles=%0d stall=%b req=%b expected 3/0/0", stall_cnt, STALL, bus.MEM_REQ);
        else passed++;
        total++;
        if (WB_VALID !== 1'b1 || WB_READ_DATA !== 32'hCAFEF00D || {WB_REG_WRITE, WB_MEM_TO_REG} !== 2'b11 || WB_WRITE_REGISTER !== 5'd7)
            $display("FAIL load_wb: got v=%b rd=%h rw/m2r=%b%b wreg=%0d expected 1/cafef00d/11/7",
                     WB_VALID, WB_READ_DATA, WB_REG_WRITE, WB_MEM_TO_REG, WB_WRITE_REGISTER);
        else passed++;
        // a stray ack in IDLE must be ignored
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h12345678;
        tick();
        bus.MEM_ACK = 1'b0;
        total++;
        if (WB_VALID !== 1'b0 || WB_READ_DATA !== 32'hCAFEF00D || STALL !== 1'b0)
            $display("FAIL idle_ack: got v=%b rd=%h stall=%b expected 0/cafef00d/0", WB_VALID, WB_READ_DATA, STALL);
        else passed++;
    endtask

    task automatic test_store();
        issue(5'b00100, 32'h20, 32'h55, 5'd9);
        total++;
        if (bus.MEM_REQ !== 1'b1 || bus.MEM_WE !== 1'b1 || bus.MEM_WDATA !== 32'h55 || bus.MEM_ADDR !== 32'h20)
            $display("FAIL store_req: got req=%b we=%b wd=%h addr=%h expected 1/1/00000055/00000020",
                     bus.MEM_REQ, bus.MEM_WE, bus.MEM_WDATA, bus.MEM_ADDR);
        else passed++;
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hDEADBEEF;
        tick();
        bus.MEM_ACK = 1'b0;
        total++;
        if (WB_VALID !== 1'b1 || WB_REG_WRITE !== 1'b0 || bus.MEM_REQ !== 1'b0 || WB_READ_DATA !== 32'hCAFEF00D)
            $display("FAIL store_done: got v=%b rw=%b req=%b rd=%h expected 1/0/0/cafef00d",
                     WB_VALID, WB_REG_WRITE, bus.MEM_REQ, WB_READ_DATA);
        else passed++;
    endtask

    task automatic test_branch();
        ZERO = 1'b1; BRANCH_TARGET = 32'h40;
        issue(5'b10000, 32'h0, 32'h0, 5'd0);
        total++;
        if (PC_SRC !== 1'b1 || BRANCH_TARGET_OUT !== 32'h40)
            $display("FAIL branch_taken: got pc_src=%b tgt=%h expected 1/00000040", PC_SRC, BRANCH_TARGET_OUT);
        else passed++;
        ZERO = 1'b0; BRANCH_TARGET = 32'h80;
        issue(5'b10000, 32'h0, 32'h0, 5'd0);
        total++;
        if (PC_SRC !== 1'b0 || WB_VALID !== 1'b1)
            $display("FAIL branch_not_taken: got pc_src=%b v=%b expected 0/1", PC_SRC, WB_VALID);
        else passed++;
        ZERO = 1'b1; BRANCH_TARGET = 32'h40;
        issue(5'b10000, 32'h0, 32'h0, 5'd0);
        tick();
        total++;
        if (PC_SRC !== 1'b0)
            $display("FAIL branch_pulse: got pc_src=%b expected 0", PC_SRC);
        else passed++;
        ZERO = 1'b0;
    endtask

    task automatic test_misaligned();
        do_reset();
        issue(5'b01011, 32'h102, 32'h0, 5'd4);
        total++;
        if ({bus.MEM_REQ, STALL, BUS_ERROR, WB_VALID, WB_REG_WRITE} !== 5'b00110)
            $display("FAIL misaligned: got req/stall/err/v/rw=%b expected 00110",
                     {bus.MEM_REQ, STALL, BUS_ERROR, WB_VALID, WB_REG_WRITE});
        else passed++;
        tick();
        total++;
        if (BUS_ERROR !== 1'b1 || WB_VALID !== 1'b0)
            $display("FAIL error_sticky: got err=%b v=%b expected 1/0", BUS_ERROR, WB_VALID);
        else passed++;
    endtask

    task automatic test_timeout();
        int busy = 0;
        do_reset();
        issue(5'b01011, 32'h200, 32'h0, 5'd5);
        while (bus.MEM_REQ === 1'b1 && busy < 40) begin
            busy++;
            tick();
        end
        total++;
        if (busy != 16)
            $display("FAIL timeout_cycles: got %0d busy cycles expected 16", busy);
        else passed++;
        total++;
        if ({BUS_ERROR, WB_VALID, WB_REG_WRITE, STALL} !== 4'b1100)
            $display("FAIL timeout_abort: got err/v/rw/stall=%b expected 1100", {BUS_ERROR, WB_VALID, WB_REG_WRITE, STALL});
        else passed++;
    endtask

    task automatic test_ack_final_cycle();
        do_reset();
        issue(5'b01011, 32'h300, 32'h0, 5'd6);
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (bus.MEM_REQ !== 1'b1 || STALL !== 1'b1)
            $display("FAIL final_cycle_req: got req=%b stall=%b expected 1/1", bus.MEM_REQ, STALL);
        else passed++;
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h0BADCAFE;
        tick();
        bus.MEM_ACK = 1'b0;
        total++;
        if ({BUS_ERROR, WB_VALID, WB_REG_WRITE, bus.MEM_REQ} !== 4'b0110 || WB_READ_DATA !== 32'h0BADCAFE)
            $display("FAIL final_cycle_ack: got err/v/rw/req=%b rd=%h expected 0110/0badcafe",
                     {BUS_ERROR, WB_VALID, WB_REG_WRITE, bus.MEM_REQ}, WB_READ_DATA);
        else passed++;
    endtask

    task automatic test_reset_mid_busy();
        issue(5'b01011, 32'h400, 32'h0, 5'd8);
        tick();
        total++;
        if (STALL !== 1'b1 || bus.MEM_REQ !== 1'b1)
            $display("FAIL pre_reset_busy: got stall=%b req=%b expected 1/1", STALL, bus.MEM_REQ);
        else passed++;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        total++;
        if ({STALL, bus.MEM_REQ, bus.MEM_WE, PC_SRC, WB_VALID, WB_REG_WRITE, WB_MEM_TO_REG, HIT_OUT, BUS_ERROR} !== 9'b0 ||
            {bus.MEM_ADDR, WB_ALU_RESULT, WB_READ_DATA, WB_WRITE_REGISTER} !== 101'b0)
            $display("FAIL reset_mid_busy: got stall=%b req=%b addr=%h alu=%h rd=%h", STALL, bus.MEM_REQ,
                     bus.MEM_ADDR, WB_ALU_RESULT, WB_READ_DATA);
        else passed++;
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_misaligned();
        test_timeout();
        test_ack_final_cycle();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
